sprite_line_scheduler: RTL

Per-scanline sprite scheduler for the framebuffer-less graphics core. During each horizontal blanking interval it scans the sprite descriptor table and selects the sprites that intersect the next scanline, up to the number of hardware sprite slots. It writes the selected sprite index and row into the slot table that the VGA core renders from, then commits a valid mask. It sits between the descriptor RAM/registers and vga_core, and is sequenced by the core's h_active falling edge.

---
 rtl/sprite_line_scheduler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: during hblank, scans the descriptor table and
// fills the hardware slot table with the lowest-indexed sprites that hit the next line.
module sprite_line_scheduler #(
    parameter int NUM_SPRITES = 8,
    parameter int NUM_SLOTS   = 4,
    parameter int Y_WIDTH     = 10,
    parameter int H_WIDTH     = 6,
    localparam int SPR_W      = $clog2(NUM_SPRITES),
    localparam int SLOT_W     = $clog2(NUM_SLOTS)
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 hblank_start,
    input  logic [Y_WIDTH-1:0]   next_line,
    output logic [SPR_W-1:0]     desc_addr,
    input  logic                 desc_en,
    input  logic [Y_WIDTH-1:0]   desc_y,
    input  logic [H_WIDTH-1:0]   desc_h,
    output logic                 slot_we,
    output logic [SLOT_W-1:0]    slot_idx,
    output logic [SPR_W-1:0]     slot_sprite,
    output logic [H_WIDTH-1:0]   slot_row,
    output logic [NUM_SLOTS-1:0] slot_valid,
    output logic                 commit,
    output logic                 overflow,
    output logic                 busy
);

    localparam int CNT_W = SPR_W + 2;
    localparam int HC_W  = SLOT_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [Y_WIDTH-1:0]   line_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [HC_W-1:0]      hit_count_reg;
    logic                 drop_reg;
    logic [SPR_W-1:0]     desc_addr_reg;
    logic                 slot_we_reg;
    logic [SLOT_W-1:0]    slot_idx_reg;
    logic [SPR_W-1:0]     slot_sprite_reg;
    logic [H_WIDTH-1:0]   slot_row_reg;
    logic [NUM_SLOTS-1:0] slot_valid_reg;
    logic                 overflow_reg;

    logic                 eval_active;
    logic                 scan_last;
    logic                 hit;
    logic                 slots_full;
    logic [Y_WIDTH-1:0]   diff;
    logic [SPR_W-1:0]     eval_idx;
    logic [NUM_SLOTS-1:0] valid_mask;

    // cnt_reg counts cycles spent in SCAN; descriptor i returns when cnt_reg == i+1,
    // and the extra cycle at NUM_SPRITES+1 lets the last hit land in the count.
    assign eval_active = (state_reg == SCAN) && (cnt_reg != '0)
                         && (cnt_reg <= CNT_W'(NUM_SPRITES));
    assign scan_last   = (state_reg == SCAN) && (cnt_reg == CNT_W'(NUM_SPRITES + 1));
    assign eval_idx    = SPR_W'(cnt_reg - CNT_W'(1));
    assign diff        = line_reg - desc_y;
    assign hit         = eval_active && desc_en
                         && (diff < {{(Y_WIDTH - H_WIDTH){1'b0}}, desc_h});
    assign slots_full  = (hit_count_reg == HC_W'(NUM_SLOTS));

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_mask
            assign valid_mask[gi] = (hit_count_reg > HC_W'(gi));
        end
    endgenerate

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (hblank_start) state_next = SCAN;
            SCAN:    if (scan_last) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            line_reg        <= '0;
            cnt_reg         <= '0;
            hit_count_reg   <= '0;
            drop_reg        <= 1'b0;
            desc_addr_reg   <= '0;
            slot_we_reg     <= 1'b0;
            slot_idx_reg    <= '0;
            slot_sprite_reg <= '0;
            slot_row_reg    <= '0;
            slot_valid_reg  <= '0;
            overflow_reg    <= 1'b0;
        end else begin
            slot_we_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (hblank_start) begin
                        line_reg      <= next_line;
                        cnt_reg       <= '0;
                        hit_count_reg <= '0;
                        drop_reg      <= 1'b0;
                        desc_addr_reg <= '0;
                    end
                end
                SCAN: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (desc_addr_reg != SPR_W'(NUM_SPRITES - 1)) begin
                        desc_addr_reg <= desc_addr_reg + SPR_W'(1);
                    end
                    if (hit) begin
                        if (slots_full) begin
                            drop_reg <= 1'b1;
                        end else begin
                            slot_we_reg     <= 1'b1;
                            slot_idx_reg    <= hit_count_reg[SLOT_W-1:0];
                            slot_sprite_reg <= eval_idx;
                            slot_row_reg    <= diff[H_WIDTH-1:0];
                            hit_count_reg   <= hit_count_reg + HC_W'(1);
                        end
                    end
                    if (scan_last) begin
                        slot_valid_reg <= valid_mask;
                        overflow_reg   <= drop_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign desc_addr   = desc_addr_reg;
    assign slot_we     = slot_we_reg;
    assign slot_idx    = slot_idx_reg;
    assign slot_sprite = slot_sprite_reg;
    assign slot_row    = slot_row_reg;
    assign slot_valid  = slot_valid_reg;
    assign overflow    = overflow_reg;
    assign commit      = (state_reg == COMMIT);
    assign busy        = (state_reg != IDLE);

endmodule
